// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants: XLEN, default reset PC, fetch entry.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package riscv_pkg;

  localparam int XLEN = 32;

  // First fetch address after reset unless the top overrides it.
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Width of the count of stale responses still to be discarded. Repeated
  // redirects can stack up stale responses beyond DEPTH, bounded by how many
  // requests the memory pipeline can hold.
  localparam int DROP_W = 8;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential next fetch address; wraps 32'hFFFF_FFFC -> 0.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  // Force word alignment on an externally supplied target.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry FIFO with synchronous flush and occupancy count.
// Latency: head visible on out_data_o the cycle after push; zero-cycle read of head.
// Backpressure: in_ready_o low when full; out_valid_o = count != 0, pop on valid & ready.
//
// Ports: clk, rst_n (async active-low), flush_i (empties FIFO at next edge,
// overrides push/pop), in_valid_i/in_ready_o/in_data_i (write side),
// out_valid_o/out_ready_i/out_data_o (read side, head entry), count_o.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = $bits(fetch_entry_t),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push;
  logic             pop;

  // Pointer increment with wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready_o  = (cnt_q != CNT_W'(DEPTH));
  assign out_valid_o = (cnt_q != '0);
  assign out_data_o  = mem_q[rd_q];
  assign count_o     = cnt_q;

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      // Flush wins: a pop in the same cycle still completes at the
      // consumer, every other entry is discarded.
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push && !flush_i) mem_q[wr_q] <= in_data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order requests to imem, buffered output to decode, redirect with stale-response drop.
// Latency: request issues the cycle after reset release / redirect; response to decoder one cycle after imem_rsp_valid.
// Backpressure: out_ready low fills the buffer; requests stop when in-flight + buffered reaches DEPTH.
//
// Ports: clk, rst_n (async active-low); imem_req_valid/ready/addr (fetch request);
// imem_rsp_valid/data (in-order response); redirect_valid/pc (from execute);
// out_valid/ready/instr/pc (to decoder).
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              credit_ok;
  logic              req_fire;
  logic              rsp_keep;

  logic [CNT_W-1:0]  inflight;     // kept requests awaiting a response
  logic [XLEN-1:0]   pcq_head;
  logic              pcq_in_rdy;
  logic              pcq_out_vld;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_in_rdy;
  fetch_entry_t      fifo_in;
  fetch_entry_t      fifo_head;

  // Ready/valid flags that the credit rule makes redundant; kept visible
  // here rather than left dangling.
  logic              unused_flags;
  assign unused_flags = &{pcq_in_rdy, fifo_in_rdy};

  // Credit covers both outstanding kept requests and buffered entries, so
  // every kept response is guaranteed a free buffer slot. rst_n gates the
  // request combinationally so nothing is offered while reset is held.
  assign credit_ok      = ({1'b0, inflight} + {1'b0, fifo_count}) < SUM_W'(DEPTH);
  assign imem_req_valid = rst_n & ~redirect_valid & credit_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response is kept only when no stale responses are pending and no
  // redirect is invalidating it this very cycle.
  assign rsp_keep = imem_rsp_valid & ~redirect_valid & (drop_q == '0) & pcq_out_vld;

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d = pc_align(redirect_pc);
      // Everything outstanding becomes stale: previously stale ones plus
      // all kept ones, less any response being consumed right now.
      drop_d = drop_q + DROP_W'(inflight) - DROP_W'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_incr(pc_q);
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  // Addresses of kept in-flight requests, in issue order. Its occupancy is
  // the in-flight count; a redirect clears it since those become stale.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_pc_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .in_valid_i  (req_fire),
    .in_ready_o  (pcq_in_rdy),
    .in_data_i   (pc_q),
    .out_valid_o (pcq_out_vld),
    .out_ready_i (rsp_keep),
    .out_data_o  (pcq_head),
    .count_o     (inflight)
  );

  assign fifo_in.pc    = pcq_head;
  assign fifo_in.instr = imem_rsp_data;

  // Instruction buffer towards decode; a redirect empties it at the next
  // edge, while a handshake in the redirect cycle still delivers its head.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_ibuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .in_valid_i  (rsp_keep),
    .in_ready_o  (fifo_in_rdy),
    .in_data_i   (fifo_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (fifo_head),
    .count_o     (fifo_count)
  );

  assign out_instr = fifo_head.instr;
  assign out_pc    = fifo_head.pc;

endmodule
